// File: rtl/tcb_rvmodel_pkg.sv
// Shared definitions for the RISC-V test-model control block:
// register offsets, status bit positions and a byte-enable merge helper.
package tcb_rvmodel_pkg;

    // register offsets decoded from adr[4:0]
    localparam logic [4:0] ADR_DATA_BEGIN = 5'h00;
    localparam logic [4:0] ADR_DATA_END   = 5'h08;
    localparam logic [4:0] ADR_HALT       = 5'h10;
    localparam logic [4:0] ADR_CONSOLE    = 5'h18;
    localparam logic [4:0] ADR_TIMEOUT    = 5'h1C;

    // bit positions in the halt/status register
    localparam int BIT_HALT    = 0;
    localparam int BIT_TIMEOUT = 1;

    // replace only the bytes whose enable bit is set
    function automatic logic [31:0] ben_merge(
        input logic [31:0] cur,
        input logic [31:0] wdt,
        input logic [3:0]  ben
    );
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (ben[b]) res[8*b +: 8] = wdt[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tcb_rvmodel_fifo.sv
// Console byte FIFO: FD entries (power of 2), registered fill count,
// full/empty decoded from the count register. Storage is not reset;
// pointers and count are cleared asynchronously.
module tcb_rvmodel_fifo #(
    parameter int FD = 16,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DW-1:0]        din,
    input  logic                 pop,
    output logic [DW-1:0]        dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(FD):0]  count
);

    localparam int AW = $clog2(FD);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [FD];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(FD));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    // byte storage, written on accepted push only
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    // pointers wrap naturally modulo FD; count tracks occupancy 0..FD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/tcb_rvmodel_ctl.sv
// TCB-attached control block for the RISC-V test model: signature region
// bounds, sticky halt flag, console byte FIFO and optional cycle timeout.
// Define TCB_RVMODEL_TIMEOUT_EN to build the cycle counter, timeout flag and
// the timeout limit register at 0x1C; otherwise 0x1C reads 0.
module tcb_rvmodel_ctl
    import tcb_rvmodel_pkg::*;
#(
    parameter int          DAW = 22,
    parameter int          DDW = 32,
    parameter int          DBW = DDW/8,
    parameter int          FD  = 16,
    parameter logic [31:0] TMO = 32'd0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bus_vld,
    input  logic           bus_wen,
    input  logic [DAW-1:0] bus_adr,
    input  logic [DBW-1:0] bus_ben,
    input  logic [DDW-1:0] bus_wdt,
    output logic [DDW-1:0] bus_rdt,
    output logic           bus_rdy,
    output logic           con_vld,
    output logic [7:0]     con_dat,
    input  logic           con_rdy,
    output logic [DDW-1:0] data_begin,
    output logic [DDW-1:0] data_end,
    output logic           halt,
    output logic           timeout
);

    localparam int CW = $clog2(FD) + 1;

    logic [4:0]     adr;
    logic           trn;
    logic           wr;
    logic           rd;
    logic           con_push;
    logic           con_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_cnt;
    logic [DDW-1:0] limit_rd;
    logic [DDW-1:0] rd_val;
    logic           adr_unused;

    assign adr        = bus_adr[4:0];
    assign adr_unused = ^bus_adr[DAW-1:5];

    // stall only a console write against a full FIFO (registered full flag)
    assign bus_rdy  = !(bus_vld && bus_wen && (adr == ADR_CONSOLE) && fifo_full);
    assign trn      = bus_vld && bus_rdy;
    assign wr       = trn && bus_wen;
    assign rd       = trn && !bus_wen;
    assign con_push = wr && (adr == ADR_CONSOLE) && bus_ben[0];
    assign con_vld  = !fifo_empty;
    assign con_pop  = con_vld && con_rdy;

    tcb_rvmodel_fifo #(
        .FD (FD),
        .DW (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (con_push),
        .din   (bus_wdt[7:0]),
        .pop   (con_pop),
        .dout  (con_dat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // signature bounds with byte-lane writes; halt is set-only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_begin <= '0;
            data_end   <= '0;
            halt       <= 1'b0;
        end else if (wr) begin
            if (adr == ADR_DATA_BEGIN) data_begin <= ben_merge(data_begin, bus_wdt, bus_ben);
            if (adr == ADR_DATA_END)   data_end   <= ben_merge(data_end, bus_wdt, bus_ben);
            if ((adr == ADR_HALT) && bus_ben[0] && bus_wdt[0]) halt <= 1'b1;
        end
    end

`ifdef TCB_RVMODEL_TIMEOUT_EN
    logic [DDW-1:0] limit;
    logic [DDW-1:0] counter;

    assign limit_rd = limit;

    // timeout limit register, reset to TMO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit <= TMO;
        end else if (wr && (adr == ADR_TIMEOUT)) begin
            limit <= ben_merge(limit, bus_wdt, bus_ben);
        end
    end

    // saturating cycle counter, frozen once the test has ended
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
        end else if (!halt && !timeout && (counter != '1)) begin
            counter <= counter + 1'b1;
        end
    end

    // sticky timeout once a nonzero limit is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if ((limit != '0) && (counter >= limit)) begin
            timeout <= 1'b1;
        end
    end
`else
    localparam logic [31:0] TMO_UNUSED = TMO;

    assign timeout  = 1'b0;
    assign limit_rd = '0;
`endif

    // read decode; unmapped offsets return 0
    always_comb begin
        rd_val = '0;
        case (adr)
            ADR_DATA_BEGIN: rd_val = data_begin;
            ADR_DATA_END:   rd_val = data_end;
            ADR_HALT: begin
                rd_val[BIT_HALT]    = halt;
                rd_val[BIT_TIMEOUT] = timeout;
            end
            ADR_CONSOLE:    rd_val = {{(DDW-CW){1'b0}}, fifo_cnt};
            ADR_TIMEOUT:    rd_val = limit_rd;
            default:        rd_val = '0;
        endcase
    end

    // read data registered on the read transfer and held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdt <= '0;
        end else if (rd) begin
            bus_rdt <= rd_val;
        end
    end

endmodule
